// File: rtl/coder_pkg.sv
// Shared constants and state type for the QPP interleaver stream block.
package coder_pkg;

    // Block sizes in bits and their QPP coefficients (f1, f2).
    localparam int DEF_K_LARGE = 6144;
    localparam int DEF_K_SMALL = 1056;
    localparam int DEF_F1_L    = 263;
    localparam int DEF_F2_L    = 480;
    localparam int DEF_F1_S    = 17;
    localparam int DEF_F2_S    = 66;

    // Block controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/qpp_index_gen.sv
// Incremental QPP index generator: pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*f2,
// all modulo K, using only adders and one conditional subtract per add.
module qpp_index_gen
    import coder_pkg::*;
#(
    parameter int  K_LARGE = DEF_K_LARGE,
    parameter int  K_SMALL = DEF_K_SMALL,
    parameter int  F1_L    = DEF_F1_L,
    parameter int  F2_L    = DEF_F2_L,
    parameter int  F1_S    = DEF_F1_S,
    parameter int  F2_S    = DEF_F2_S,
    localparam int IDX_W   = $clog2(K_LARGE)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             step,
    input  logic             k_large,
    output logic [IDX_W-1:0] pi
);

    // Seed and increment constants, already reduced into [0,K).
    localparam int G0_L = (F1_L + F2_L) % K_LARGE;
    localparam int G0_S = (F1_S + F2_S) % K_SMALL;
    localparam int DG_L = (2 * F2_L) % K_LARGE;
    localparam int DG_S = (2 * F2_S) % K_SMALL;

    logic [IDX_W-1:0] pi_q, pi_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [IDX_W:0]   k_mod;
    logic [IDX_W-1:0] g0_sel;
    logic [IDX_W-1:0] dg_sel;

    // Operands are both in [0,m), so a single subtract brings the sum back into range.
    function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b,
                                                 input logic [IDX_W:0]   m);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= m) begin
            s = s - m;
        end
        return s[IDX_W-1:0];
    endfunction

    // Coefficient select and next-index arithmetic.
    always_comb begin
        k_mod  = k_large ? (IDX_W+1)'(K_LARGE) : (IDX_W+1)'(K_SMALL);
        g0_sel = k_large ? IDX_W'(G0_L) : IDX_W'(G0_S);
        dg_sel = k_large ? IDX_W'(DG_L) : IDX_W'(DG_S);
        pi_d   = add_mod(pi_q, g_q, k_mod);
        g_d    = add_mod(g_q, dg_sel, k_mod);
    end

    // Index registers: start reseeds at pi(0), step advances by one position.
    always_ff @(posedge clk) begin
        if (clear) begin
            pi_q <= '0;
            g_q  <= '0;
        end else if (start) begin
            pi_q <= '0;
            g_q  <= g0_sel;
        end else if (step) begin
            pi_q <= pi_d;
            g_q  <= g_d;
        end
    end

    assign pi = pi_q;

endmodule

// File: rtl/coder_interleaver_stream.sv
// Byte-loaded block buffer streamed out as (c[i], c[pi(i)]) bit pairs.
module coder_interleaver_stream
    import coder_pkg::*;
#(
    parameter int K_LARGE = DEF_K_LARGE,
    parameter int K_SMALL = DEF_K_SMALL,
    parameter int F1_L    = DEF_F1_L,
    parameter int F2_L    = DEF_F2_L,
    parameter int F1_S    = DEF_F1_S,
    parameter int F2_S    = DEF_F2_S
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       k_size_6144,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       outi,
    output logic       outpii,
    output logic       out_last,
    output logic       busy
);

    localparam int IDX_W  = $clog2(K_LARGE);
    localparam int BYTE_W = IDX_W - 3;

    localparam logic [BYTE_W-1:0] NB_L_M1 = BYTE_W'(K_LARGE / 8 - 1);
    localparam logic [BYTE_W-1:0] NB_S_M1 = BYTE_W'(K_SMALL / 8 - 1);
    localparam logic [IDX_W-1:0]  KL_M1   = IDX_W'(K_LARGE - 1);
    localparam logic [IDX_W-1:0]  KS_M1   = IDX_W'(K_SMALL - 1);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic              k_q, k_d;

    logic              wr_en;
    logic [BYTE_W-1:0] wr_addr;
    logic              gen_start;
    logic              gen_step;
    logic              gen_k;
    logic [IDX_W-1:0]  pi_idx;
    logic [BYTE_W-1:0] last_byte;
    logic [IDX_W-1:0]  last_idx;

    // Bit buffer; never cleared because every bit of a block is rewritten before it is read.
    logic mem_q [K_LARGE];

    // Next-state, handshake and write control.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        i_d        = i_q;
        k_d        = k_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = byte_cnt_q;
        gen_start  = 1'b0;
        gen_step   = 1'b0;
        last_byte  = k_q ? NB_L_M1 : NB_S_M1;
        last_idx   = k_q ? KL_M1 : KS_M1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    k_d        = k_size_6144;
                    byte_cnt_d = BYTE_W'(1);
                    state_d    = LOAD;
                    if ((k_size_6144 ? NB_L_M1 : NB_S_M1) == '0) begin
                        byte_cnt_d = '0;
                        i_d        = '0;
                        gen_start  = 1'b1;
                        state_d    = STREAM;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (byte_cnt_q == last_byte) begin
                        byte_cnt_d = '0;
                        i_d        = '0;
                        gen_start  = 1'b1;
                        state_d    = STREAM;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    gen_step = 1'b1;
                    if (i_q == last_idx) begin
                        i_d     = '0;
                        state_d = IDLE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; clear wins over any concurrent handshake.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            i_q        <= '0;
            k_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            i_q        <= i_d;
            k_q        <= k_d;
        end
    end

    // Byte write, MSB of the byte lands on the lowest bit index.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            for (int b = 0; b < 8; b++) begin
                mem_q[{wr_addr, 3'(b)}] <= in_byte[7-b];
            end
        end
    end

    // In IDLE the block size is being latched this cycle, so use the live select.
    assign gen_k = (state_q == IDLE) ? k_size_6144 : k_q;

    qpp_index_gen #(
        .K_LARGE (K_LARGE),
        .K_SMALL (K_SMALL),
        .F1_L    (F1_L),
        .F2_L    (F2_L),
        .F1_S    (F1_S),
        .F2_S    (F2_S)
    ) u_qpp (
        .clk     (clk),
        .clear   (clear),
        .start   (gen_start),
        .step    (gen_step),
        .k_large (gen_k),
        .pi      (pi_idx)
    );

    assign outi     = out_valid ? mem_q[i_q] : 1'b0;
    assign outpii   = out_valid ? mem_q[pi_idx] : 1'b0;
    assign out_last = out_valid && (i_q == last_idx);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_coder_interleaver_stream.sv
// Directed bench for coder_interleaver_stream with a closed-form QPP reference model.
module tb_coder_interleaver_stream;

    localparam int KL = 6144;
    localparam int KS = 1056;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       k_size_6144 = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, outi, outpii, out_last, busy;

    coder_interleaver_stream dut (
        .clk         (clk),
        .clear       (clear),
        .k_size_6144 (k_size_6144),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .outi        (outi),
        .outpii      (outpii),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit cur_bits [KL];
    bit cur_kl = 1'b0;
    bit rec_i [KL];
    bit rec_p [KL];
    bit ref_i [KL];
    bit ref_p [KL];
    int load_count = 0;   // blocks fully loaded (driver)
    int done_count = 0;   // blocks fully streamed (compare process)
    int cidx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int k_of(input bit kl);
        return kl ? KL : KS;
    endfunction

    // Closed-form QPP permutation straight from its definition.
    function automatic int pi_model(input int i, input bit kl);
        longint k, f1, f2, ii;
        k  = longint'(k_of(kl));
        f1 = kl ? 64'd263 : 64'd17;
        f2 = kl ? 64'd480 : 64'd66;
        ii = longint'(i);
        return int'((f1 * ii + f2 * ii * ii) % k);
    endfunction

    function automatic logic [7:0] pat(input int j, input int seed);
        return 8'((j * 37 + seed * 101) ^ (j >> 2) ^ (seed << 3));
    endfunction

    task automatic check_perm(input bit kl);
        bit seen [KL];
        int dups = 0;
        int p;
        for (int i = 0; i < k_of(kl); i++) begin
            p = pi_model(i, kl);
            if (seen[p]) dups++;
            seen[p] = 1'b1;
        end
        chk(kl ? "model_perm_large" : "model_perm_small", dups, 0);
    endtask

    // Per-cycle compare of the stream against the model.
    always @(negedge clk) begin
        if (clear) begin
            cidx = 0;
        end else if (out_valid) begin
            if (load_count == done_count) begin
                chk("stale_out_valid", out_valid, 0);
            end else begin
                chk("outi", outi, cur_bits[cidx]);
                chk("outpii", outpii, cur_bits[pi_model(cidx, cur_kl)]);
                chk("out_last", out_last, (cidx == k_of(cur_kl) - 1));
                chk("stream_in_ready", in_ready, 0);
                chk("stream_busy", busy, 1);
                if (out_ready) begin
                    rec_i[cidx] = outi;
                    rec_p[cidx] = outpii;
                    if (cidx == k_of(cur_kl) - 1) begin
                        cidx = 0;
                        done_count++;
                    end else begin
                        cidx++;
                    end
                end
            end
        end
    end

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        load_count = done_count;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outi", outi, 0);
        chk("rst_outpii", outpii, 0);
    endtask

    // stop_at > 0 abandons the load after that many bytes (DUT left in LOAD).
    task automatic load_block(input bit kl, input int seed, input bit gaps,
                              input bit ktog, input int stop_at);
        int nb;
        int lim;
        int g;
        logic [7:0] b;
        nb  = k_of(kl) / 8;
        lim = (stop_at > 0) ? stop_at : nb;
        cur_kl = kl;
        out_ready = 1'b0;
        for (int j = 0; j < lim; j++) begin
            b = pat(j, seed);
            for (int t = 0; t < 8; t++) cur_bits[8*j+t] = b[7-t];
            if (gaps && j > 0) begin
                g = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_byte  = b;
            k_size_6144 = (j == 0) ? kl : (ktog ? ($urandom_range(0, 1) == 1) : kl);
            @(negedge clk);
            chk("load_in_ready", in_ready, 1);
            chk("load_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (stop_at == 0) begin
            load_count++;
            @(negedge clk);
            chk("first_pair_latency", out_valid, 1);
            @(posedge clk); #1;
        end
    endtask

    // abort_after > 0 asserts clear after that many stream cycles.
    task automatic run_stream(input bit stall, input int abort_after);
        int n = 0;
        while (done_count != load_count) begin
            if (abort_after > 0 && n == abort_after) begin
                do_clear();
                out_ready = 1'b0;
                return;
            end
            out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(posedge clk); #1;
            n++;
            if (n > 3 * KL + 200) begin
                chk("stream_timeout", done_count, load_count);
                load_count = done_count;
            end
        end
        out_ready = 1'b0;
        chk("end_busy", busy, 0);
        chk("end_in_ready", in_ready, 1);
    endtask

    task automatic save_ref(input int k);
        for (int i = 0; i < k; i++) begin
            ref_i[i] = rec_i[i];
            ref_p[i] = rec_p[i];
        end
    endtask

    task automatic cmp_ref(input int k);
        int mism = 0;
        for (int i = 0; i < k; i++) begin
            if (ref_i[i] != rec_i[i] || ref_p[i] != rec_p[i]) mism++;
        end
        chk("stall_identical", mism, 0);
    endtask

    initial begin
        // Pin the reference model to hand-computed values.
        chk("model_pi_s1", pi_model(1, 0), 83);
        chk("model_pi_s2", pi_model(2, 0), 298);
        chk("model_pi_s1055", pi_model(1055, 0), 49);
        chk("model_pi_l1", pi_model(1, 1), 743);
        chk("model_pi_l2", pi_model(2, 1), 2446);
        chk("model_pi_l6143", pi_model(6143, 1), 217);
        check_perm(1'b0);
        check_perm(1'b1);

        repeat (2) @(posedge clk);
        #1;
        do_clear();

        // Small block, no stalls.
        load_block(1'b0, 1, 1'b0, 1'b0, 0);
        run_stream(1'b0, 0);

        // Large block, no stalls, then the same data gapped and stalled.
        load_block(1'b1, 2, 1'b0, 1'b0, 0);
        run_stream(1'b0, 0);
        save_ref(KL);
        load_block(1'b1, 2, 1'b1, 1'b0, 0);
        run_stream(1'b1, 0);
        cmp_ref(KL);

        // Small block, same comparison.
        load_block(1'b0, 3, 1'b0, 1'b0, 0);
        run_stream(1'b0, 0);
        save_ref(KS);
        load_block(1'b0, 3, 1'b1, 1'b0, 0);
        run_stream(1'b1, 0);
        cmp_ref(KS);

        // Clear at byte 400 of a large load, with a byte offered during clear.
        load_block(1'b1, 4, 1'b0, 1'b0, 400);
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        do_clear();
        load_block(1'b0, 5, 1'b0, 1'b0, 0);
        run_stream(1'b0, 0);

        // Clear in the middle of a stream, then a fresh block.
        load_block(1'b0, 6, 1'b0, 1'b0, 0);
        run_stream(1'b1, 300);
        load_block(1'b0, 7, 1'b1, 1'b0, 0);
        run_stream(1'b1, 0);

        // Size select toggled mid-load, then back-to-back block.
        load_block(1'b0, 8, 1'b0, 1'b1, 0);
        run_stream(1'b0, 0);
        load_block(1'b1, 9, 1'b0, 1'b1, 0);
        run_stream(1'b0, 0);

        chk("blocks_streamed", done_count, 9);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coder_interleaver_stream.md
CODER_INTERLEAVER_STREAM -- requirements
Module: coder_interleaver_stream

Interface
REQ-001 SHALL have parameter K_LARGE, default 6144, meaning large block size in bits (multiple of 8).
REQ-002 SHALL have parameter K_SMALL, default 1056, meaning small block size in bits (multiple of 8).
REQ-003 SHALL have parameters F1_L/F2_L, defaults 263/480, meaning QPP coefficients for K_LARGE.
REQ-004 SHALL have parameters F1_S/F2_S, defaults 17/66, meaning QPP coefficients for K_SMALL.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 clear  in  1  reset, synchronous, active-high.
REQ-007 k_size_6144  in  1  1 = K_LARGE, 0 = K_SMALL; sampled only on first byte of a block.
REQ-008 in_valid  in  1  byte on in_byte is offered.
REQ-009 in_byte  in  8  input data byte.
REQ-010 in_ready  out  1  block accepts a byte this cycle.
REQ-011 out_ready  in  1  sink accepts the current output bit pair.
REQ-012 out_valid  out  1  outi/outpii hold a valid bit pair.
REQ-013 outi  out  1  systematic bit c[i].
REQ-014 outpii  out  1  interleaved bit c[pi(i)].
REQ-015 out_last  out  1  high with out_valid on index i = K-1.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement three states: IDLE, LOAD, STREAM.
REQ-018 IDLE: in_ready=1, out_valid=0; in_valid=1 writes byte 0, latches K from k_size_6144, goes to LOAD (or STREAM if K/8 = 1).
REQ-019 LOAD: in_ready=1; each in_valid&in_ready writes the next byte; the byte completing K/8 moves to STREAM next cycle.
REQ-020 Byte j SHALL map to buffer bits c[8j..8j+7], with in_byte[7] -> c[8j] (MSB first).
REQ-021 k_size_6144 changes after the first byte of a block SHALL be ignored until the next block.
REQ-022 STREAM: in_ready=0, out_valid=1; outi=c[i], outpii=c[pi(i)], i starting at 0.
REQ-023 pi(i) = (f1*i + f2*i*i) mod K, with (f1,f2) selected by the latched K.
REQ-024 pi SHALL be generated incrementally, without multipliers: pi(0)=0, g(0)=(f1+f2) mod K, pi(i+1)=(pi(i)+g(i)) mod K, g(i+1)=(g(i)+2*f2) mod K.
REQ-025 Each modular add SHALL use operands already in [0,K) and one conditional subtract of K; index width = clog2(K_LARGE).
REQ-026 out_valid&out_ready SHALL advance i and pi by one in the same cycle; with out_ready=0, outputs and indices SHALL hold stable.
REQ-027 The first valid bit pair SHALL appear the cycle after the last byte is accepted; throughput is one pair per cycle under out_ready=1.
REQ-028 out_last=1 exactly when i=K-1; acceptance of that pair returns to IDLE next cycle with in_ready=1.
REQ-029 Buffer contents SHALL NOT be cleared between blocks; every bit is rewritten before it is read.

Reset
REQ-030 clear SHALL force: state=IDLE, byte counter=0, i=0, pi=0, g=0, latched K=K_SMALL.
REQ-031 After clear, outputs SHALL be in_ready=1, out_valid=0, out_last=0, busy=0, and outi=outpii=0.
REQ-032 clear SHALL take priority over every simultaneous event, including mid-LOAD and mid-STREAM; the partial block is discarded.

Structure
REQ-033 K_LARGE/K_SMALL and their QPP coefficients SHALL be defined in the shared package coder_pkg, along with the state enumeration.
REQ-034 Index generation (pi and g registers, modular adders, coefficient select) SHALL be a sub-module named qpp_index_gen, with ports clk, clear, start, step, k_large, pi.

Verification
REQ-035 K_SMALL block, 132 bytes, out_ready=1 -> pi sequence starts 0, 83, 298; pi(1055)=49; out_last on the 1056th pair.
REQ-036 K_LARGE block, 768 bytes -> pi(1)=743, pi(2)=2446, pi(6143)=217; outi stream equals input bits MSB-first.
REQ-037 Random data, both K values -> outpii stream matches a software model of cout[i]=cin[pi(i)], with no index repeated.
REQ-038 out_ready toggled randomly in STREAM and in_valid gapped in LOAD -> streams are bit-identical to the no-stall run.
REQ-039 clear asserted at byte 400 of a K_LARGE load, then a K_SMALL block -> the K_SMALL block is correct and no stale output is produced.
REQ-040 k_size_6144 toggled mid-LOAD, plus a back-to-back second block -> first block length is unchanged, and the second block's byte 0 is accepted the cycle after out_last.
